// File: rtl/maze_bitmap_generator.sv
// Random perfect-maze writer: binary-tree carve driven by a Galois LFSR.
// Ports: clk, reset (async low), start, maze_width, maze_height -> busy, done, err, path_data.
module maze_bitmap_generator #(
    parameter int          MAX_DIM = 100,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [6:0]                   maze_width,
    input  logic [6:0]                   maze_height,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [MAX_DIM*MAX_DIM-1:0]   path_data
);

    localparam int BITS = MAX_DIM * MAX_DIM;
    localparam int IW   = $clog2(BITS);

    typedef enum logic [1:0] {IDLE, CLEAR, CARVE, OPEN} state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] lfsr;
    logic [6:0]  weff;
    logic [6:0]  heff;
    logic [6:0]  cx;
    logic [6:0]  cy;
    logic [6:0]  link_x;
    logic [6:0]  link_y;
    logic        dims_ok;
    logic        row_end;
    logic        last_cell;

    function automatic logic [IW-1:0] idx(input logic [6:0] x, input logic [6:0] y);
        return IW'(x) + IW'(MAX_DIM) * IW'(y);
    endfunction

    assign dims_ok = (maze_width  >= 7'd5) && (maze_width  <= 7'(MAX_DIM)) &&
                     (maze_height >= 7'd5) && (maze_height <= 7'(MAX_DIM));

    // cx is always odd and Weff-2 is odd, so "cx+2 > Weff-2" is just equality
    assign row_end   = (cx == weff - 7'd2);
    assign last_cell = row_end && (cy == heff - 7'd2);

    // Link target; the (1,1) cell links to itself, i.e. no extra bit
    always_comb begin
        link_x = cx;
        link_y = cy;
        if (cx == 7'd1 && cy == 7'd1) begin
            link_x = cx;
        end else if (cy == 7'd1) begin
            link_x = cx - 7'd1;
        end else if (cx == 7'd1) begin
            link_y = cy - 7'd1;
        end else if (lfsr[0]) begin
            link_y = cy - 7'd1;
        end else begin
            link_x = cx - 7'd1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start && dims_ok) state_nx = CLEAR;
            CLEAR: state_nx = CARVE;
            CARVE: if (last_cell) state_nx = OPEN;
            OPEN:  state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: LFSR, dimension latch, carve cursor and bitmap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr      <= SEED;
            path_data <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            weff      <= '0;
            heff      <= '0;
            cx        <= '0;
            cy        <= '0;
        end else begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (dims_ok) begin
                            weff <= maze_width[0]  ? maze_width  : maze_width  - 7'd1;
                            heff <= maze_height[0] ? maze_height : maze_height - 7'd1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    path_data <= '0;
                    cx        <= 7'd1;
                    cy        <= 7'd1;
                end
                CARVE: begin
                    path_data[idx(cx, cy)]         <= 1'b1;
                    path_data[idx(link_x, link_y)] <= 1'b1;
                    if (row_end) begin
                        cx <= 7'd1;
                        cy <= cy + 7'd2;
                    end else begin
                        cx <= cx + 7'd2;
                    end
                end
                OPEN: begin
                    path_data[idx(7'd1, 7'd0)]                <= 1'b1;
                    path_data[idx(weff - 7'd2, heff - 7'd1)]  <= 1'b1;
                    done                                      <= 1'b1;
                end
            endcase
        end
    end

endmodule
